mm_sched: RTL and testbench
===========================

Name: mm_sched

Overview:
- Instruction scheduler in front of the matrix-multiply unit (mm_top).
- Takes 128-bit MM instructions from the top-level dispatcher and queues them in a small FIFO.
- Validates the buffer-select fields of each instruction, issues legal ones to mm_top one at a time, and holds each instruction stable until done_from_mm.
- Counts retired and dropped instructions; flags a hung MM with a timeout and halts.

Parameters:
- FIFO_DEPTH, 4, instruction queue depth; power of 2, >=2.
- TIMEOUT_W, 20, width of the WAIT-state cycle counter.
- TIMEOUT_LIMIT, 20'hFFFFF, WAIT cycles before timeout; must fit in TIMEOUT_W.

Ports:
- ap_clk  in  1  clock.
- areset  in  1  synchronous reset, active-high.
- enable  in  1  when 0, no new instruction is popped; an in-flight instruction still completes.
- inst_in  in  128  instruction from dispatcher.
- inst_in_valid  in  1  inst_in valid.
- inst_in_ready  out  1  FIFO can accept; equals !full.
- instruction_to_mm  out  128  registered instruction to mm_top.
- valid_to_mm  out  1  one-cycle start pulse to mm_top.
- done_from_mm  in  1  MM completion pulse.
- busy  out  1  FSM not IDLE, or FIFO non-empty.
- retired_count  out  16  instructions completed; wraps.
- illegal_count  out  8  instructions dropped as illegal; saturates at 255.
- illegal_pulse  out  1  one-cycle pulse per dropped instruction.
- timeout_err  out  1  sticky; cleared only by reset.

Behaviour:
- Reset (sync, areset=1 at a rising edge):
  - FIFO is emptied; FSM goes to IDLE.
  - All outputs return to 0, except inst_in_ready=1.
  - This applies mid-operation too: any in-flight instruction is abandoned, and done_from_mm in the reset cycle is ignored.
- Push:
  - An instruction is written when inst_in_valid && inst_in_ready at the clock edge.
  - A push while full cannot occur, because ready=0.
  - Simultaneous push and pop is allowed when not full; occupancy is then unchanged.
- Legality check, applied at pop:
  - inst[4:1] (input buffer select) must be exactly one of 0001, 0010, 0100, 1000.
  - inst[10:7] (output buffer select) must be 0100 or 1000.
  - inst[4:1] must not equal inst[10:7]; input and output cannot share buffer 2A/2B.
- FSM states: IDLE, ISSUE, WAIT, HALT.
- IDLE: if enable && FIFO non-empty, pop the head.
  - Legal: load instruction_to_mm, go to ISSUE.
  - Illegal: discard; pulse illegal_pulse next cycle; increment illegal_count; stay in IDLE. A further pop may happen on the following cycle.
- ISSUE: valid_to_mm=1 for exactly this cycle; go to WAIT.
- WAIT:
  - valid_to_mm=0; the timeout counter increments each cycle.
  - done_from_mm=1: retired_count+1, counter cleared, go to IDLE.
  - Counter == TIMEOUT_LIMIT without done: set timeout_err, go to HALT.
  - If done and the limit are reached in the same cycle, done wins.
- HALT: no further pops. FIFO still accepts pushes until full. Exit only by reset.
- Stability: instruction_to_mm is held constant from the ISSUE cycle through the done cycle. mm_top decodes its fields combinationally, so the value must not glitch. It keeps its last value in IDLE.
- done_from_mm is ignored in IDLE, ISSUE and HALT.
- Latency:
  - Push at edge t into an empty FIFO with the FSM in IDLE and enable=1: valid_to_mm is high in cycle t+2.
  - Back-to-back: done in cycle d (WAIT) with the FIFO non-empty gives the next valid_to_mm in cycle d+2.
- busy = (state!=IDLE) || !empty.
- retired_count wraps at 2^16; illegal_count saturates.

Test Plan:
1. Reset, then push one legal instruction (inst[4:1]=0001, inst[10:7]=0100) at edge 0 -> valid_to_mm high only in cycle 2, instruction_to_mm equals the pushed value; done at cycle 10 -> retired_count=1, busy=0 at cycle 11.
2. Push 5 instructions back-to-back with done withheld -> inst_in_ready=0 after the 5th accept (1 in flight, 4 queued); done pulses -> each issued in order, 2 cycles after the prior done; retired_count=5.
3. Push inst[10:7]=0001, then inst[4:1]=inst[10:7]=0100, then one legal instruction -> two illegal_pulse cycles, illegal_count=2; only the legal one reaches valid_to_mm.
4. TIMEOUT_LIMIT=16, issue, no done -> timeout_err=1 after 16 WAIT cycles, FSM in HALT; the queued instruction is never issued; areset -> everything cleared.
5. enable=0 with 2 queued -> no valid_to_mm; enable=1 -> issue 1 cycle later. Also assert areset during WAIT -> valid_to_mm=0, FIFO empty; a late done_from_mm does not change retired_count.

Source files
------------

// File: rtl/mm_sched.sv
// mm_sched: queues MM instructions, validates buffer selects, issues legal
// ones to mm_top one at a time and watches for a hung MM with a timeout.
module mm_sched #(
  parameter int unsigned          FIFO_DEPTH    = 4,
  parameter int unsigned          TIMEOUT_W     = 20,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT_LIMIT = 20'hFFFFF
) (
  input  logic         ap_clk,
  input  logic         areset,
  input  logic         enable,
  input  logic [127:0] inst_in,
  input  logic         inst_in_valid,
  output logic         inst_in_ready,
  output logic [127:0] instruction_to_mm,
  output logic         valid_to_mm,
  input  logic         done_from_mm,
  output logic         busy,
  output logic [15:0]  retired_count,
  output logic [7:0]   illegal_count,
  output logic         illegal_pulse,
  output logic         timeout_err
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HALT} state_e;

  state_e               state_q, state_d;
  logic [127:0]         mem_q [FIFO_DEPTH];
  logic [AW-1:0]        rd_ptr_q, wr_ptr_q;
  logic [AW:0]          occ_q;
  logic [TIMEOUT_W-1:0] tmo_q, tmo_inc;
  logic [127:0]         inst_q;
  logic [15:0]          retired_q;
  logic [7:0]           illegal_q;
  logic                 ipulse_q, tmo_err_q;

  logic                 empty, full, push, pop;
  logic                 load, drop, retire, set_tmo;
  logic                 head_legal, tmo_hit;
  logic [127:0]         head;
  logic [3:0]           in_sel, out_sel;

  assign empty   = (occ_q == '0);
  assign full    = (occ_q == (AW+1)'(FIFO_DEPTH));
  assign push    = inst_in_valid && !full;

  assign head    = mem_q[rd_ptr_q];
  assign in_sel  = head[4:1];
  assign out_sel = head[10:7];
  // Input select must be one-hot, output must be buffer 2A/2B, and they
  // must not name the same buffer.
  assign head_legal = (in_sel inside {4'b0001, 4'b0010, 4'b0100, 4'b1000}) &&
                      (out_sel inside {4'b0100, 4'b1000}) &&
                      (in_sel != out_sel);

  assign tmo_inc = tmo_q + TIMEOUT_W'(1);
  assign tmo_hit = (tmo_inc == TIMEOUT_LIMIT);

  // FSM state register
  always_ff @(posedge ap_clk) begin
    if (areset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic; done takes priority over the timeout
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (enable && !empty && head_legal) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT: begin
        if (done_from_mm) state_d = IDLE;
        else if (tmo_hit) state_d = HALT;
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs and datapath strobes decoded from the current state
  always_comb begin
    valid_to_mm = 1'b0;
    pop         = 1'b0;
    load        = 1'b0;
    drop        = 1'b0;
    retire      = 1'b0;
    set_tmo     = 1'b0;
    unique case (state_q)
      IDLE: begin
        pop  = enable && !empty;
        load = pop && head_legal;
        drop = pop && !head_legal;
      end
      ISSUE: valid_to_mm = 1'b1;
      WAIT: begin
        retire  = done_from_mm;
        set_tmo = !done_from_mm && tmo_hit;
      end
      default: ;
    endcase
  end

  // FIFO pointers and occupancy
  always_ff @(posedge ap_clk) begin
    if (areset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({push, pop})
        2'b10:   occ_q <= occ_q + (AW+1)'(1);
        2'b01:   occ_q <= occ_q - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  // FIFO storage; contents are don't-care while empty so no reset
  always_ff @(posedge ap_clk) begin
    if (push) mem_q[wr_ptr_q] <= inst_in;
  end

  // Issued instruction, counters, pulses and the WAIT-cycle timer
  always_ff @(posedge ap_clk) begin
    if (areset) begin
      inst_q    <= '0;
      retired_q <= '0;
      illegal_q <= '0;
      ipulse_q  <= 1'b0;
      tmo_err_q <= 1'b0;
      tmo_q     <= '0;
    end else begin
      if (load)                      inst_q    <= head;
      if (retire)                    retired_q <= retired_q + 16'd1;
      if (drop && illegal_q != 8'hFF) illegal_q <= illegal_q + 8'd1;
      if (set_tmo)                   tmo_err_q <= 1'b1;
      ipulse_q <= drop;
      tmo_q    <= (state_q == WAIT && !done_from_mm) ? tmo_inc : '0;
    end
  end

  assign inst_in_ready     = !full;
  assign busy              = (state_q != IDLE) || !empty;
  assign instruction_to_mm = inst_q;
  assign retired_count     = retired_q;
  assign illegal_count     = illegal_q;
  assign illegal_pulse     = ipulse_q;
  assign timeout_err       = tmo_err_q;

endmodule

// File: tb/tb_mm_sched.sv
// tb_mm_sched: directed stimulus for mm_sched with a queue-based reference
// model compared every cycle, plus hand-computed checks that pin the model.
module tb_mm_sched;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned LIMIT = 16;

  logic         ap_clk;
  logic         areset;
  logic         enable;
  logic [127:0] inst_in;
  logic         inst_in_valid;
  logic         inst_in_ready;
  logic [127:0] instruction_to_mm;
  logic         valid_to_mm;
  logic         done_from_mm;
  logic         busy;
  logic [15:0]  retired_count;
  logic [7:0]   illegal_count;
  logic         illegal_pulse;
  logic         timeout_err;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned ecnt   = 0;
  bit          chk_en = 0;

  mm_sched #(
    .FIFO_DEPTH    (DEPTH),
    .TIMEOUT_W     (20),
    .TIMEOUT_LIMIT (20'd16)
  ) dut (
    .ap_clk            (ap_clk),
    .areset            (areset),
    .enable            (enable),
    .inst_in           (inst_in),
    .inst_in_valid     (inst_in_valid),
    .inst_in_ready     (inst_in_ready),
    .instruction_to_mm (instruction_to_mm),
    .valid_to_mm       (valid_to_mm),
    .done_from_mm      (done_from_mm),
    .busy              (busy),
    .retired_count     (retired_count),
    .illegal_count     (illegal_count),
    .illegal_pulse     (illegal_pulse),
    .timeout_err       (timeout_err)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, ecnt);
    end
  endtask

  task automatic chkw(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %032h expected %032h (edge %0d)", name, act, exp, ecnt);
    end
  endtask

  function automatic bit legal(input logic [127:0] x);
    logic [3:0] i;
    logic [3:0] o;
    i = x[4:1];
    o = x[10:7];
    return ($countones(i) == 1) && (o == 4'b0100 || o == 4'b1000) && (i != o);
  endfunction

  function automatic logic [127:0] mk(input logic [3:0] isel, input logic [3:0] osel);
    logic [127:0] x;
    x = {$urandom, $urandom, $urandom, $urandom};
    x[4:1]  = isel;
    x[10:7] = osel;
    return x;
  endfunction

  // Reference model: a queue of pending instructions plus the age of the
  // one outstanding at mm_top (age 0 = start pulse, age k = k-th wait cycle).
  logic [127:0] mq[$];
  bit           m_inflight, m_halted, m_ipulse, m_tmo;
  int unsigned  m_age;
  logic [15:0]  m_ret;
  logic [7:0]   m_ill;
  logic [127:0] m_inst;

  always @(posedge ap_clk) begin
    bit           acc;
    bit           nxt_pulse;
    logic [127:0] x;
    ecnt++;
    if (areset) begin
      mq.delete();
      m_inflight = 0;
      m_halted   = 0;
      m_age      = 0;
      m_ipulse   = 0;
      m_tmo      = 0;
      m_ret      = '0;
      m_ill      = '0;
      m_inst     = '0;
    end else begin
      acc       = inst_in_valid && (mq.size() < DEPTH);
      nxt_pulse = 0;
      if (m_inflight) begin
        if (m_age == 0) m_age = 1;
        else if (done_from_mm) begin
          m_ret      = m_ret + 16'd1;
          m_inflight = 0;
        end else if (m_age == LIMIT) begin
          m_tmo      = 1;
          m_halted   = 1;
          m_inflight = 0;
        end else m_age++;
      end else if (!m_halted && enable && mq.size() != 0) begin
        x = mq.pop_front();
        if (legal(x)) begin
          m_inflight = 1;
          m_age      = 0;
          m_inst     = x;
        end else begin
          nxt_pulse = 1;
          if (m_ill != 8'hFF) m_ill = m_ill + 8'd1;
        end
      end
      if (acc) mq.push_back(inst_in);
      m_ipulse = nxt_pulse;
    end
  end

  always @(negedge ap_clk) begin
    if (chk_en) begin
      chk ("m_valid",   32'(valid_to_mm),   32'(m_inflight && m_age == 0));
      chkw("m_inst",    instruction_to_mm,  m_inst);
      chk ("m_ready",   32'(inst_in_ready), 32'(mq.size() < DEPTH));
      chk ("m_busy",    32'(busy),          32'(m_inflight || m_halted || mq.size() != 0));
      chk ("m_retired", 32'(retired_count), 32'(m_ret));
      chk ("m_illegal", 32'(illegal_count), 32'(m_ill));
      chk ("m_ipulse",  32'(illegal_pulse), 32'(m_ipulse));
      chk ("m_timeout", 32'(timeout_err),   32'(m_tmo));
    end
  end

  // All tasks start and end at a falling edge.
  task automatic do_reset();
    areset        = 1'b1;
    inst_in_valid = 1'b0;
    done_from_mm  = 1'b0;
    @(negedge ap_clk);
    areset = 1'b0;
  endtask

  task automatic push(input logic [127:0] x);
    inst_in       = x;
    inst_in_valid = 1'b1;
    @(negedge ap_clk);
    inst_in_valid = 1'b0;
  endtask

  task automatic pulse_done();
    done_from_mm = 1'b1;
    @(negedge ap_clk);
    done_from_mm = 1'b0;
  endtask

  task automatic wait_edge(input int unsigned target);
    while (ecnt < target) @(negedge ap_clk);
  endtask

  task automatic wait_valid(input int unsigned lim, output bit found, output int unsigned at);
    found = 0;
    at    = 0;
    for (int unsigned i = 0; i < lim && !found; i++) begin
      if (valid_to_mm === 1'b1) begin
        found = 1;
        at    = ecnt;
      end else @(negedge ap_clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got still running expected finished");
    $fatal(1);
  end

  initial begin
    logic [127:0] a, b, c;
    logic [127:0] v[5];
    logic [127:0] t3[3];
    int unsigned  t, at, done_edge, pulses, vcnt;
    bit           found;

    areset = 1'b1; enable = 1'b1; inst_in = '0; inst_in_valid = 1'b0; done_from_mm = 1'b0;
    @(negedge ap_clk);
    @(negedge ap_clk);
    areset = 1'b0;
    chk_en = 1;
    chk ("rst_ready",   32'(inst_in_ready), 32'd1);
    chk ("rst_busy",    32'(busy),          32'd0);
    chk ("rst_valid",   32'(valid_to_mm),   32'd0);
    chk ("rst_retired", 32'(retired_count), 32'd0);
    chkw("rst_inst",    instruction_to_mm,  128'd0);

    // 1: single legal instruction, start pulse in cycle t+2, retire on done
    do_reset();
    a = mk(4'b0001, 4'b0100);
    t = ecnt + 1;
    push(a);
    chk ("t1_valid_c1", 32'(valid_to_mm), 32'd0);
    @(negedge ap_clk);
    chk ("t1_valid_c2", 32'(valid_to_mm), 32'd1);
    chkw("t1_inst",     instruction_to_mm, a);
    @(negedge ap_clk);
    chk ("t1_valid_c3", 32'(valid_to_mm), 32'd0);
    chkw("t1_inst_hold", instruction_to_mm, a);
    wait_edge(t + 9);
    pulse_done();
    chk ("t1_retired", 32'(retired_count), 32'd1);
    chk ("t1_busy",    32'(busy),          32'd0);

    // 2: five back-to-back pushes fill the queue; issue order and d+2 latency
    do_reset();
    for (int i = 0; i < 5; i++) begin
      v[i] = mk(4'b0001 << (i % 4), (i % 2 == 0) ? 4'b1000 : 4'b0100);
      if (v[i][4:1] == v[i][10:7]) v[i][10:7] = 4'b0100;
      chk("t2_ready_pre", 32'(inst_in_ready), 32'd1);
      push(v[i]);
    end
    chk("t2_ready_full", 32'(inst_in_ready), 32'd0);
    done_edge = 0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        wait_valid(40, found, at);
        chk("t2_issue_seen", 32'(found), 32'd1);
        chk("t2_latency",    32'(at - done_edge), 32'd1);
      end
      chkw("t2_order", instruction_to_mm, v[i]);
      @(negedge ap_clk);
      @(negedge ap_clk);
      done_edge = ecnt + 1;
      pulse_done();
    end
    chk("t2_retired", 32'(retired_count), 32'd5);
    chk("t2_busy",    32'(busy),          32'd0);

    // 3: two illegal instructions dropped, one legal issued
    do_reset();
    t3[0] = mk(4'b0010, 4'b0001);
    t3[1] = mk(4'b0100, 4'b0100);
    t3[2] = mk(4'b1000, 4'b0100);
    pulses = 0;
    vcnt   = 0;
    for (int c2 = 0; c2 < 10; c2++) begin
      inst_in_valid = (c2 < 3);
      if (c2 < 3) inst_in = t3[c2];
      @(negedge ap_clk);
      if (illegal_pulse === 1'b1) pulses++;
      if (valid_to_mm === 1'b1) begin
        vcnt++;
        chkw("t3_issued", instruction_to_mm, t3[2]);
      end
    end
    inst_in_valid = 1'b0;
    pulse_done();
    chk("t3_pulses",  32'(pulses),        32'd2);
    chk("t3_valids",  32'(vcnt),          32'd1);
    chk("t3_illegal", 32'(illegal_count), 32'd2);
    chk("t3_retired", 32'(retired_count), 32'd1);

    // 4a: done in the 16th wait cycle beats the timeout
    do_reset();
    a = mk(4'b0001, 4'b1000);
    push(a);
    wait_valid(10, found, at);
    chk("t4_issue_a", 32'(found), 32'd1);
    wait_edge(at + 16);
    pulse_done();
    chk("t4_done_wins", 32'(timeout_err),   32'd0);
    chk("t4_retired_a", 32'(retired_count), 32'd1);

    // 4b: no done -> timeout after 16 wait cycles, halt, queued one stays
    b = mk(4'b0010, 4'b0100);
    c = mk(4'b0001, 4'b0100);
    push(b);
    push(c);
    wait_valid(10, found, at);
    chk ("t4_issue_b", 32'(found), 32'd1);
    chkw("t4_inst_b",  instruction_to_mm, b);
    wait_edge(at + 16);
    chk ("t4_tmo_pre",  32'(timeout_err), 32'd0);
    @(negedge ap_clk);
    chk ("t4_tmo_set",  32'(timeout_err),   32'd1);
    chk ("t4_halt_busy", 32'(busy),         32'd1);
    chk ("t4_halt_ready", 32'(inst_in_ready), 32'd1);
    pulse_done();
    vcnt = 0;
    for (int c2 = 0; c2 < 10; c2++) begin
      if (valid_to_mm === 1'b1) vcnt++;
      @(negedge ap_clk);
    end
    chk ("t4_no_issue",   32'(vcnt),          32'd0);
    chk ("t4_retired_h",  32'(retired_count), 32'd1);
    chk ("t4_tmo_sticky", 32'(timeout_err),   32'd1);
    do_reset();
    chk ("t4_rst_tmo",   32'(timeout_err),   32'd0);
    chk ("t4_rst_busy",  32'(busy),          32'd0);
    chk ("t4_rst_ready", 32'(inst_in_ready), 32'd1);
    chk ("t4_rst_ret",   32'(retired_count), 32'd0);
    chkw("t4_rst_inst",  instruction_to_mm,  128'd0);

    // 5: enable gating, then reset while waiting with done in the reset cycle
    do_reset();
    enable = 1'b0;
    push(mk(4'b0001, 4'b0100));
    push(mk(4'b0100, 4'b1000));
    vcnt = 0;
    for (int c2 = 0; c2 < 6; c2++) begin
      if (valid_to_mm === 1'b1) vcnt++;
      @(negedge ap_clk);
    end
    chk("t5_gated",      32'(vcnt), 32'd0);
    chk("t5_gated_busy", 32'(busy), 32'd1);
    enable = 1'b1;
    @(negedge ap_clk);
    chk("t5_issue_1cyc", 32'(valid_to_mm), 32'd1);
    @(negedge ap_clk);
    @(negedge ap_clk);
    areset       = 1'b1;
    done_from_mm = 1'b1;
    @(negedge ap_clk);
    areset       = 1'b0;
    done_from_mm = 1'b0;
    chk("t5_rst_valid", 32'(valid_to_mm),   32'd0);
    chk("t5_rst_busy",  32'(busy),          32'd0);
    chk("t5_rst_ret",   32'(retired_count), 32'd0);
    @(negedge ap_clk);
    pulse_done();
    @(negedge ap_clk);
    chk("t5_late_done", 32'(retired_count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
